// File: rtl/rd_burst_sched.sv
// Read-side burst scheduler: round-robin pick of four AR FIFOs, beat address
// generation, device read sequencing and R channel handshake.
module rd_burst_sched #(
  parameter int unsigned BusWidth = 32,
  parameter int unsigned tagbits  = 2,
  parameter int unsigned EntryW   = 49 + tagbits
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [3:0]            fifo_empty,
  input  logic [4*EntryW-1:0]   fifo_dout,
  output logic [3:0]            fifo_read,
  output logic [BusWidth-1:0]   address_out,
  output logic                  devread,
  input  logic [BusWidth-1:0]   data_in,
  output logic [tagbits-1:0]    RID,
  output logic [BusWidth-1:0]   RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int unsigned NBytes   = BusWidth / 8;
  localparam int unsigned ProtLsb  = 0;
  localparam int unsigned CacheLsb = 3;
  localparam int unsigned LockLsb  = 7;
  localparam int unsigned BurstLsb = 9;
  localparam int unsigned SizeLsb  = 11;
  localparam int unsigned LenLsb   = 13;
  localparam int unsigned AddrLsb  = 17;
  localparam int unsigned IdLsb    = AddrLsb + BusWidth;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, SEND} state_t;

  state_t                state;
  logic [1:0]            ptr;
  logic                  dphase;
  logic [tagbits-1:0]    b_id;
  logic [BusWidth-1:0]   b_addr;
  logic [BusWidth-1:0]   cur_addr;
  logic [3:0]            b_len;
  logic [3:0]            cnt;
  logic [1:0]            b_size;
  logic [1:0]            b_burst;
  logic [1:0]            b_lock;
  logic [3:0]            b_cache;
  logic [2:0]            b_prot;
  logic                  b_err;

  logic                  any_c;
  logic [1:0]            gnt_c;
  logic [EntryW-1:0]     head_c;
  logic [tagbits-1:0]    h_id;
  logic [BusWidth-1:0]   h_addr;
  logic [3:0]            h_len;
  logic [1:0]            h_size;
  logic [1:0]            h_burst;
  logic                  err_c;
  logic [BusWidth-1:0]   nb_c;
  logic [BusWidth-1:0]   wsize_c;
  logic [BusWidth-1:0]   lower_c;
  logic [BusWidth-1:0]   step_c;
  logic [BusWidth-1:0]   next_c;
  logic [BusWidth-1:0]   rdata_c;

  // First non-empty FIFO searching from ptr+1; i=4 wraps back to ptr itself
  always_comb begin
    any_c = 1'b0;
    gnt_c = ptr;
    for (int i = 1; i <= 4; i++) begin
      if (!any_c && !fifo_empty[ptr + 2'(i)]) begin
        any_c = 1'b1;
        gnt_c = ptr + 2'(i);
      end
    end
  end

  always_comb begin
    head_c = '0;
    for (int i = 0; i < 4; i++) begin
      if (gnt_c == 2'(i)) head_c = fifo_dout[i*EntryW +: EntryW];
    end
  end

  assign h_id    = head_c[IdLsb +: tagbits];
  assign h_addr  = head_c[AddrLsb +: BusWidth];
  assign h_len   = head_c[LenLsb +: 4];
  assign h_size  = head_c[SizeLsb +: 2];
  assign h_burst = head_c[BurstLsb +: 2];

  assign err_c = (h_size == 2'b11) || (h_burst == 2'b11) ||
                 ((h_burst == 2'b10) && !((h_len == 4'd1) || (h_len == 4'd3) ||
                                          (h_len == 4'd7) || (h_len == 4'd15)));

  // Next beat address for the latched burst
  always_comb begin
    nb_c    = BusWidth'(1) << b_size;
    wsize_c = nb_c * (BusWidth'(b_len) + BusWidth'(1));
    lower_c = b_addr & ~(wsize_c - BusWidth'(1));
    step_c  = cur_addr + nb_c;
    case (b_burst)
      2'b01:   next_c = (cur_addr & ~(nb_c - BusWidth'(1))) + nb_c;
      2'b10:   next_c = (step_c == lower_c + wsize_c) ? lower_c : step_c;
      default: next_c = cur_addr;
    endcase
  end

  // Keep only the low 1<<SIZE byte lanes; error beats return zero data
  always_comb begin
    rdata_c = '0;
    for (int b = 0; b < NBytes; b++) begin
      if (!b_err && (BusWidth'(b) < nb_c)) rdata_c[b*8 +: 8] = data_in[b*8 +: 8];
    end
  end

  logic unused_fields;
  assign unused_fields = ^{b_lock, b_cache, b_prot};

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= IDLE;
      ptr         <= 2'd3;
      dphase      <= 1'b0;
      b_id        <= '0;
      b_addr      <= '0;
      cur_addr    <= '0;
      b_len       <= '0;
      cnt         <= '0;
      b_size      <= '0;
      b_burst     <= '0;
      b_lock      <= '0;
      b_cache     <= '0;
      b_prot      <= '0;
      b_err       <= 1'b0;
      fifo_read   <= '0;
      address_out <= '0;
      devread     <= 1'b0;
      RID         <= '0;
      RDATA       <= '0;
      RRESP       <= '0;
      RLAST       <= 1'b0;
      RVALID      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_c) begin
            fifo_read <= 4'b0001 << gnt_c;
            ptr       <= gnt_c;
            b_id      <= h_id;
            b_addr    <= h_addr;
            cur_addr  <= h_addr;
            b_len     <= h_len;
            cnt       <= h_len;
            b_size    <= h_size;
            b_burst   <= h_burst;
            b_lock    <= head_c[LockLsb +: 2];
            b_cache   <= head_c[CacheLsb +: 4];
            b_prot    <= head_c[ProtLsb +: 3];
            b_err     <= err_c;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          fifo_read   <= '0;
          address_out <= cur_addr;
          devread     <= !b_err;
          dphase      <= 1'b0;
          state       <= WAIT;
        end
        // First cycle: strobe drops; second cycle: device data is valid
        WAIT: begin
          if (!dphase) begin
            devread <= 1'b0;
            dphase  <= 1'b1;
          end else begin
            RID    <= b_id;
            RDATA  <= rdata_c;
            RRESP  <= b_err ? 2'b10 : 2'b00;
            RLAST  <= (cnt == 4'd0);
            RVALID <= 1'b1;
            dphase <= 1'b0;
            state  <= SEND;
          end
        end
        // Next beat's read is issued on the accepting edge itself
        SEND: begin
          if (RREADY) begin
            RVALID <= 1'b0;
            if (RLAST) begin
              RLAST <= 1'b0;
              state <= IDLE;
            end else begin
              cnt         <= cnt - 4'd1;
              cur_addr    <= next_c;
              address_out <= next_c;
              devread     <= !b_err;
              dphase      <= 1'b0;
              state       <= WAIT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rd_burst_sched.sv
// Directed bench for rd_burst_sched: FIFO and device models feed a scoreboard
// of expected grants, device addresses and R beats.
module tb_rd_burst_sched;

  localparam int unsigned BW = 32;
  localparam int unsigned TW = 2;
  localparam int unsigned EW = 49 + TW;

  logic             ACLK = 1'b0;
  logic             ARESET;
  logic [3:0]       fifo_empty;
  logic [4*EW-1:0]  fifo_dout;
  logic [3:0]       fifo_read;
  logic [BW-1:0]    address_out;
  logic             devread;
  logic [BW-1:0]    data_in;
  logic [TW-1:0]    RID;
  logic [BW-1:0]    RDATA;
  logic [1:0]       RRESP;
  logic             RLAST;
  logic             RVALID;
  logic             RREADY;

  rd_burst_sched #(.BusWidth(BW), .tagbits(TW), .EntryW(EW)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_read(fifo_read), .address_out(address_out), .devread(devread),
    .data_in(data_in), .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  logic [EW-1:0] fq [4][$];
  rbeat_t        exp_r[$];
  logic [31:0]   exp_rd[$];
  int            exp_g[$];
  int            checks = 0;
  int            errors = 0;
  logic          mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dev_data(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i] = (fq[i].size() == 0);
      fifo_dout[i*EW +: EW] = (fq[i].size() == 0) ? '0 : fq[i][0];
    end
  endtask

  task automatic load(input int f, input logic [1:0] id, input logic [31:0] addr,
                      input logic [3:0] len, input logic [1:0] size, input logic [1:0] burst);
    logic [EW-1:0] e;
    e = {id, addr, len, size, burst, 2'b01, 4'b1010, 3'b101};
    fq[f].push_back(e);
    refresh();
  endtask

  // Independent beat model: address k computed directly from beat index
  task automatic expect_burst(input int f, input logic [1:0] id, input logic [31:0] addr,
                              input logic [3:0] len, input logic [1:0] size, input logic [1:0] burst);
    logic        err;
    logic [31:0] nb, ws, lower, a, mask, d;
    rbeat_t      rb;
    err = (size == 2'b11) || (burst == 2'b11) ||
          (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    nb    = 32'd1 << size;
    ws    = nb * (32'(len) + 32'd1);
    lower = addr & ~(ws - 32'd1);
    mask  = (size == 2'd0) ? 32'h0000_00FF : (size == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    exp_g.push_back(f);
    for (int k = 0; k <= int'(len); k++) begin
      if (burst == 2'b00)      a = addr;
      else if (burst == 2'b01) a = (k == 0) ? addr : (addr & ~(nb - 32'd1)) + 32'(k) * nb;
      else                     a = lower + (((addr - lower) + 32'(k) * nb) % ws);
      if (!err) exp_rd.push_back(a);
      d = err ? 32'h0 : (dev_data(a) & mask);
      rb.id = id; rb.data = d; rb.resp = err ? 2'b10 : 2'b00; rb.last = (k == int'(len));
      exp_r.push_back(rb);
    end
  endtask

  // FIFO pop and device response model
  initial begin
    forever begin
      @(negedge ACLK);
      if (devread === 1'b1) data_in = dev_data(address_out);
      for (int i = 0; i < 4; i++) begin
        if (fifo_read[i] === 1'b1 && fq[i].size() != 0) void'(fq[i].pop_front());
      end
      refresh();
    end
  end

  // Scoreboard monitor
  initial begin
    rbeat_t rb;
    int     g;
    forever begin
      @(negedge ACLK);
      if (mon_en) begin
        if (fifo_read !== 4'b0) begin
          if (exp_g.size() == 0) chk("unexpected_grant", 32'(fifo_read), 32'h0);
          else begin
            g = exp_g.pop_front();
            chk("grant", 32'(fifo_read), 32'(4'b0001 << g));
          end
        end
        if (devread === 1'b1) begin
          if (exp_rd.size() == 0) chk("unexpected_devread", 32'(devread), 32'h0);
          else chk("address_out", address_out, exp_rd.pop_front());
        end
        if (RVALID === 1'b1 && RREADY === 1'b1) begin
          if (exp_r.size() == 0) chk("unexpected_rbeat", 32'(RVALID), 32'h0);
          else begin
            rb = exp_r.pop_front();
            chk("RID", 32'(RID), 32'(rb.id));
            chk("RDATA", RDATA, rb.data);
            chk("RRESP", 32'(RRESP), 32'(rb.resp));
            chk("RLAST", 32'(RLAST), 32'(rb.last));
          end
        end
      end
    end
  end

  task automatic wait_rvalid();
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (RVALID === 1'b1) return;
    end
    chk("rvalid_timeout", 32'(RVALID), 32'h1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge ACLK);
      if (exp_r.size() == 0 && exp_rd.size() == 0 && exp_g.size() == 0) break;
    end
    chk("drain_rbeats", 32'(exp_r.size()), 32'h0);
    chk("drain_grants", 32'(exp_g.size()), 32'h0);
    repeat (2) @(negedge ACLK);
  endtask

  initial begin
    ARESET = 1'b1;
    RREADY = 1'b1;
    data_in = '0;
    refresh();
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_fifo_read", 32'(fifo_read), 32'h0);
    chk("rst_address_out", address_out, 32'h0);
    chk("rst_devread", 32'(devread), 32'h0);
    chk("rst_RID", 32'(RID), 32'h0);
    chk("rst_RDATA", RDATA, 32'h0);
    chk("rst_RRESP", 32'(RRESP), 32'h0);
    chk("rst_RLAST", 32'(RLAST), 32'h0);
    chk("rst_RVALID", 32'(RVALID), 32'h0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    mon_en = 1'b1;

    // Single beat with latency checks
    load(1, 2'd1, 32'h100, 4'd0, 2'b10, 2'b01);
    expect_burst(1, 2'd1, 32'h100, 4'd0, 2'b10, 2'b01);
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (fifo_read !== 4'b0) break;
    end
    chk("lat_pop", 32'(fifo_read), 32'h2);
    @(negedge ACLK);
    chk("lat_pop_pulse", 32'(fifo_read), 32'h0);
    chk("lat_devread", 32'(devread), 32'h1);
    chk("lat_address", address_out, 32'h100);
    @(negedge ACLK);
    chk("lat_rvalid_early", 32'(RVALID), 32'h0);
    @(negedge ACLK);
    chk("lat_rvalid", 32'(RVALID), 32'h1);
    drain();

    // INCR narrow, WRAP, illegal WRAP length
    @(posedge ACLK); #1;
    load(2, 2'd2, 32'h102, 4'd3, 2'b01, 2'b01);
    expect_burst(2, 2'd2, 32'h102, 4'd3, 2'b01, 2'b01);
    drain();
    @(posedge ACLK); #1;
    load(3, 2'd3, 32'h0C, 4'd3, 2'b10, 2'b10);
    expect_burst(3, 2'd3, 32'h0C, 4'd3, 2'b10, 2'b10);
    drain();
    @(posedge ACLK); #1;
    load(0, 2'd0, 32'h10, 4'd2, 2'b10, 2'b10);
    expect_burst(0, 2'd0, 32'h10, 4'd2, 2'b10, 2'b10);
    drain();

    // Backpressure on beat 2 of a FIXED burst
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    load(1, 2'd2, 32'h40, 4'd3, 2'b10, 2'b00);
    expect_burst(1, 2'd2, 32'h40, 4'd3, 2'b10, 2'b00);
    wait_rvalid();
    @(posedge ACLK); #1;
    RREADY = 1'b1;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    wait_rvalid();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid", 32'(RVALID), 32'h1);
      chk("bp_rdata", RDATA, dev_data(32'h40));
      @(negedge ACLK);
    end
    @(posedge ACLK); #1;
    RREADY = 1'b1;
    drain();

    // Round-robin from reset
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    for (int f = 0; f < 4; f++) begin
      load(f, 2'(f), 32'h300 + 32'(f) * 32'h10, 4'd0, 2'b10, 2'b01);
      expect_burst(f, 2'(f), 32'h300 + 32'(f) * 32'h10, 4'd0, 2'b10, 2'b01);
    end
    drain();
    @(posedge ACLK); #1;
    load(2, 2'd2, 32'h420, 4'd0, 2'b00, 2'b01);
    load(0, 2'd0, 32'h401, 4'd0, 2'b00, 2'b01);
    expect_burst(0, 2'd0, 32'h401, 4'd0, 2'b00, 2'b01);
    expect_burst(2, 2'd2, 32'h420, 4'd0, 2'b00, 2'b01);
    drain();

    // Reset while beat 2 of 4 is presented
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    load(3, 2'd3, 32'h200, 4'd3, 2'b10, 2'b01);
    expect_burst(3, 2'd3, 32'h200, 4'd3, 2'b10, 2'b01);
    wait_rvalid();
    @(posedge ACLK); #1;
    RREADY = 1'b1;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    wait_rvalid();
    @(posedge ACLK); #1;
    load(1, 2'd1, 32'h500, 4'd0, 2'b10, 2'b01);
    load(0, 2'd2, 32'h600, 4'd1, 2'b10, 2'b01);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    exp_r.delete();
    exp_rd.delete();
    exp_g.delete();
    expect_burst(0, 2'd2, 32'h600, 4'd1, 2'b10, 2'b01);
    expect_burst(1, 2'd1, 32'h500, 4'd0, 2'b10, 2'b01);
    @(negedge ACLK);
    chk("rstmid_RVALID", 32'(RVALID), 32'h0);
    chk("rstmid_devread", 32'(devread), 32'h0);
    chk("rstmid_fifo_read", 32'(fifo_read), 32'h0);
    @(posedge ACLK); #1;
    RREADY = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
